// File: rtl/demodchest_regs_pkg.sv
// Register map, CTRL bit positions and reset constants shared by the
// demodchest CtrlPort register block.
package demodchest_regs_pkg;

    localparam logic [31:0] REG_COMPAT     = 32'h00;
    localparam logic [31:0] REG_CTRL       = 32'h04;
    localparam logic [31:0] REG_NUM_SYM    = 32'h08;
    localparam logic [31:0] REG_THRESH     = 32'h0C;
    localparam logic [31:0] REG_PKT_CNT    = 32'h10;
    localparam logic [31:0] REG_ERR_STATUS = 32'h14;
    localparam logic [31:0] REG_SCRATCH    = 32'h18;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic [15:0] NUM_SYM_RST = 16'd14;
    localparam logic [31:0] PKT_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/demodchest_ctrlport_regs_sticky_clr_on_read.sv
// Sticky event flags: set by pulses, cleared by a status read or a global
// clear; a set arriving in the clearing cycle wins so no event is lost.
module sticky_clr_on_read #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] set,
    input  logic         rd_clr,
    input  logic         clr_all,
    output logic [W-1:0] q
);

    logic [W-1:0] keep;

    // A read returns every bit currently held, so it clears all of them.
    always_comb begin
        keep = q;
        if (rd_clr || clr_all) begin
            keep = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= keep | set;
        end
    end

endmodule

// File: rtl/demodchest_ctrlport.sv
// CtrlPort responder for demodchest: config registers out to the datapath,
// packet counter and sticky error flags back in.
module demodchest_ctrlport_regs
    import demodchest_regs_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h0,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] COMPAT    = 32'h0001_0000,
    parameter int          NUM_ERR   = 4
) (
    input  logic               ctrlport_clk,
    input  logic               ctrlport_rst_n,
    input  logic               s_ctrlport_req_wr,
    input  logic               s_ctrlport_req_rd,
    input  logic [19:0]        s_ctrlport_req_addr,
    input  logic [31:0]        s_ctrlport_req_data,
    output logic               s_ctrlport_resp_ack,
    output logic [31:0]        s_ctrlport_resp_data,
    output logic               demod_enable,
    output logic               stats_clear,
    output logic [15:0]        num_sym,
    output logic [31:0]        est_thresh,
    input  logic               pkt_done,
    input  logic [NUM_ERR-1:0] err_in
);

    // Handshake: wr/rd are single-cycle strobes with no ready; every strobe
    // hitting this window gets exactly one ack on the next cycle, and
    // resp_data is meaningful only while ack is high (0 otherwise).

    logic               hit;
    logic [31:0]        off;
    logic               aligned;
    logic               wr_hit;
    logic               rd_hit;
    logic               wr_reg;
    logic               err_rd;
    logic [31:0]        rd_data;
    logic [31:0]        scratch;
    logic [31:0]        pkt_cnt;
    logic [NUM_ERR-1:0] err_sticky;

    assign hit     = (s_ctrlport_req_addr[19:ADDR_W] == BASE_ADDR[19:ADDR_W]);
    assign off     = 32'(s_ctrlport_req_addr[ADDR_W-1:0]);
    assign aligned = (off[1:0] == 2'b00);
    assign wr_hit  = s_ctrlport_req_wr && hit;
    // A simultaneous wr+rd is handled purely as a write.
    assign rd_hit  = s_ctrlport_req_rd && !s_ctrlport_req_wr && hit;
    assign wr_reg  = wr_hit && aligned;
    assign err_rd  = rd_hit && aligned && (off == REG_ERR_STATUS);

    always_comb begin
        rd_data = '0;
        if (aligned) begin
            case (off)
                REG_COMPAT:     rd_data = COMPAT;
                REG_CTRL:       rd_data = {31'b0, demod_enable};
                REG_NUM_SYM:    rd_data = {16'b0, num_sym};
                REG_THRESH:     rd_data = est_thresh;
                REG_PKT_CNT:    rd_data = pkt_cnt;
                REG_ERR_STATUS: rd_data = 32'(err_sticky);
                REG_SCRATCH:    rd_data = scratch;
                default:        rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            s_ctrlport_resp_ack  <= 1'b0;
            s_ctrlport_resp_data <= '0;
            demod_enable         <= 1'b0;
            stats_clear          <= 1'b0;
            num_sym              <= NUM_SYM_RST;
            est_thresh           <= '0;
            scratch              <= '0;
            pkt_cnt              <= '0;
        end else begin
            s_ctrlport_resp_ack  <= wr_hit || rd_hit;
            s_ctrlport_resp_data <= rd_hit ? rd_data : '0;
            stats_clear          <= wr_reg && (off == REG_CTRL) &&
                                    s_ctrlport_req_data[CTRL_CLEAR_BIT];
            if (wr_reg) begin
                case (off)
                    REG_CTRL:    demod_enable <= s_ctrlport_req_data[CTRL_ENABLE_BIT];
                    REG_NUM_SYM: num_sym      <= s_ctrlport_req_data[15:0];
                    REG_THRESH:  est_thresh   <= s_ctrlport_req_data;
                    REG_SCRATCH: scratch      <= s_ctrlport_req_data;
                    default:     ;
                endcase
            end
            // The clear pulse beats a packet completing in the same cycle.
            if (stats_clear) begin
                pkt_cnt <= '0;
            end else if (pkt_done && (pkt_cnt != PKT_CNT_MAX)) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    sticky_clr_on_read #(
        .W(NUM_ERR)
    ) u_err_sticky (
        .clk    (ctrlport_clk),
        .rst_n  (ctrlport_rst_n),
        .set    (err_in),
        .rd_clr (err_rd),
        .clr_all(stats_clear),
        .q      (err_sticky)
    );

endmodule

// File: tb/tb_demodchest_ctrlport_regs.sv
// Bench for demodchest_ctrlport_regs: vector table, corner sequences and
// random traffic scored against a register-map model.
module tb_demodchest_ctrlport_regs;

    logic        clk;
    logic        rst_n;
    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic        resp_ack;
    logic [31:0] resp_data;
    logic        demod_enable;
    logic        stats_clear;
    logic [15:0] num_sym;
    logic [31:0] est_thresh;
    logic        pkt_done;
    logic [3:0]  err_in;

    int n_checks = 0;
    int n_err    = 0;

    demodchest_ctrlport_regs dut (
        .ctrlport_clk        (clk),
        .ctrlport_rst_n      (rst_n),
        .s_ctrlport_req_wr   (req_wr),
        .s_ctrlport_req_rd   (req_rd),
        .s_ctrlport_req_addr (req_addr),
        .s_ctrlport_req_data (req_data),
        .s_ctrlport_resp_ack (resp_ack),
        .s_ctrlport_resp_data(resp_data),
        .demod_enable        (demod_enable),
        .stats_clear         (stats_clear),
        .num_sym             (num_sym),
        .est_thresh          (est_thresh),
        .pkt_done            (pkt_done),
        .err_in              (err_in)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic        m_en;
    logic [15:0] m_num_sym;
    logic [31:0] m_thresh;
    logic [31:0] m_scratch;
    longint      m_cnt;
    logic [3:0]  m_err;
    logic        m_pend;
    logic [31:0] exp_q[$];
    logic        exp_ack_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en      = 1'b0;
        m_num_sym = 16'd14;
        m_thresh  = '0;
        m_scratch = '0;
        m_cnt     = 0;
        m_err     = '0;
        m_pend    = 1'b0;
        exp_q.delete();
        exp_ack_q.delete();
    endtask

    // One bus cycle of the register map as described, in plain terms.
    task automatic model_cycle(input logic wr, input logic rd, input logic [19:0] addr,
                               input logic [31:0] data, input logic pd, input logic [3:0] err);
        logic       hit;
        logic [7:0] off;
        logic [31:0] rdv;
        logic       rd_err;
        hit    = (addr[19:8] == 12'h000);
        off    = addr[7:0];
        rdv    = '0;
        rd_err = 1'b0;
        if (hit && rd && !wr && off[1:0] == 2'b00) begin
            case (off)
                8'h00: rdv = 32'h0001_0000;
                8'h04: rdv = {31'b0, m_en};
                8'h08: rdv = {16'b0, m_num_sym};
                8'h0C: rdv = m_thresh;
                8'h10: rdv = m_cnt[31:0];
                8'h14: begin rdv = {28'b0, m_err}; rd_err = 1'b1; end
                8'h18: rdv = m_scratch;
                default: rdv = '0;
            endcase
        end
        exp_ack_q.push_back(hit && (wr || rd));
        exp_q.push_back(rdv);
        if (m_pend) m_cnt = 0;
        else if (pd) m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        if (m_pend || rd_err) m_err = '0;
        m_err  = m_err | err;
        m_pend = 1'b0;
        if (hit && wr && off[1:0] == 2'b00) begin
            case (off)
                8'h04: begin m_en = data[0]; m_pend = data[1]; end
                8'h08: m_num_sym = data[15:0];
                8'h0C: m_thresh  = data;
                8'h18: m_scratch = data;
                default: ;
            endcase
        end
    endtask

    // driver: one cycle of inputs starting at a negedge, scored at the next
    task automatic step(input logic wr, input logic rd, input logic [19:0] addr,
                        input logic [31:0] data, input logic pd, input logic [3:0] err,
                        output logic got_ack, output logic [31:0] got_data);
        req_wr   = wr;
        req_rd   = rd;
        req_addr = addr;
        req_data = data;
        pkt_done = pd;
        err_in   = err;
        model_cycle(wr, rd, addr, data, pd, err);
        @(posedge clk);
        @(negedge clk);
        got_ack  = resp_ack;
        got_data = resp_data;
        check("ack", {31'b0, resp_ack}, {31'b0, exp_ack_q.pop_front()});
        check("rdata", resp_data, exp_q.pop_front());
        check("demod_enable", {31'b0, demod_enable}, {31'b0, m_en});
        check("stats_clear", {31'b0, stats_clear}, {31'b0, m_pend});
        check("num_sym", {16'b0, num_sym}, {16'b0, m_num_sym});
        check("est_thresh", est_thresh, m_thresh);
        req_wr   = 1'b0;
        req_rd   = 1'b0;
        req_addr = '0;
        req_data = '0;
        pkt_done = 1'b0;
        err_in   = '0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [19:0] addr;
        logic [31:0] data;
        logic        exp_ack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[19];
    logic [19:0] rand_addrs[12];

    initial begin
        logic        ga;
        logic [31:0] gd;
        logic        wr;
        logic        rd;
        int          r;

        vecs[0]  = '{1'b0, 1'b1, 20'h00000, 32'h0,          1'b1, 32'h0001_0000};
        vecs[1]  = '{1'b0, 1'b1, 20'h00008, 32'h0,          1'b1, 32'd14};
        vecs[2]  = '{1'b0, 1'b1, 20'h00004, 32'h0,          1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 20'h00018, 32'hDEAD_BEEF,  1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 20'h00018, 32'h0,          1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 20'h00100, 32'h0,          1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 20'h00118, 32'h5,          1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 20'h00018, 32'h0,          1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 1'b1, 20'h0003C, 32'h0,          1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 20'h00008, 32'hFFFF_0020,  1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 20'h00008, 32'h0,          1'b1, 32'h20};
        vecs[11] = '{1'b1, 1'b1, 20'h00018, 32'h55,         1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 20'h00018, 32'h0,          1'b1, 32'h55};
        vecs[13] = '{1'b0, 1'b1, 20'h0001A, 32'h0,          1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 20'h0001A, 32'h7,          1'b1, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 20'h00018, 32'h0,          1'b1, 32'h55};
        vecs[16] = '{1'b1, 1'b0, 20'h00000, 32'h1234_5678,  1'b1, 32'h0};
        vecs[17] = '{1'b0, 1'b1, 20'h00000, 32'h0,          1'b1, 32'h0001_0000};
        vecs[18] = '{1'b1, 1'b0, 20'h0003C, 32'hFFFF_FFFF,  1'b1, 32'h0};

        rand_addrs = '{20'h00000, 20'h00004, 20'h00008, 20'h0000C, 20'h00010, 20'h00014,
                       20'h00018, 20'h0001C, 20'h0003C, 20'h00006, 20'h00100, 20'h00114};

        rst_n    = 1'b0;
        req_wr   = 1'b0;
        req_rd   = 1'b0;
        req_addr = '0;
        req_data = '0;
        pkt_done = 1'b0;
        err_in   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'b0, resp_ack}, 32'h0);
        check("rst_rdata", resp_data, 32'h0);
        check("rst_enable", {31'b0, demod_enable}, 32'h0);
        check("rst_stats_clear", {31'b0, stats_clear}, 32'h0);
        check("rst_num_sym", {16'b0, num_sym}, 32'd14);
        check("rst_thresh", est_thresh, 32'h0);
        rst_n = 1'b1;

        // vector table
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, 1'b0, 4'h0, ga, gd);
            check($sformatf("vec%0d_ack", i), {31'b0, ga}, {31'b0, vecs[i].exp_ack});
            check($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
        end

        // threshold visible in the ack cycle
        step(1'b1, 1'b0, 20'h0000C, 32'h0000_1234, 1'b0, 4'h0, ga, gd);
        check("thresh_ack", {31'b0, ga}, 32'h1);
        check("thresh_out", est_thresh, 32'h0000_1234);

        // packet counter and clear
        repeat (5) step(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 4'h0, ga, gd);
        step(1'b0, 1'b1, 20'h00010, 32'h0, 1'b0, 4'h0, ga, gd);
        check("pkt_cnt_5", gd, 32'd5);
        step(1'b1, 1'b0, 20'h00004, 32'h3, 1'b0, 4'h0, ga, gd);
        check("clear_pulse", {31'b0, stats_clear}, 32'h1);
        check("enable_set", {31'b0, demod_enable}, 32'h1);
        step(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 4'h0, ga, gd);
        check("clear_one_cycle", {31'b0, stats_clear}, 32'h0);
        step(1'b0, 1'b1, 20'h00010, 32'h0, 1'b0, 4'h0, ga, gd);
        check("pkt_cnt_cleared", gd, 32'h0);
        step(1'b0, 1'b1, 20'h00004, 32'h0, 1'b0, 4'h0, ga, gd);
        check("ctrl_reads_1", gd, 32'h1);

        // clear-on-read race
        step(1'b0, 1'b0, 20'h0, 32'h0, 1'b0, 4'b0001, ga, gd);
        step(1'b0, 1'b1, 20'h00014, 32'h0, 1'b0, 4'b0100, ga, gd);
        check("err_read1", gd, 32'h1);
        step(1'b0, 1'b1, 20'h00014, 32'h0, 1'b0, 4'h0, ga, gd);
        check("err_read2", gd, 32'h4);
        step(1'b0, 1'b1, 20'h00014, 32'h0, 1'b0, 4'h0, ga, gd);
        check("err_read3", gd, 32'h0);

        // saturation
        force dut.pkt_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.pkt_cnt;
        m_cnt = 64'hFFFF_FFFE;
        repeat (3) step(1'b0, 1'b0, 20'h0, 32'h0, 1'b1, 4'h0, ga, gd);
        step(1'b0, 1'b1, 20'h00010, 32'h0, 1'b0, 4'h0, ga, gd);
        check("pkt_cnt_sat", gd, 32'hFFFF_FFFF);

        // back-to-back reads
        step(1'b0, 1'b1, 20'h00000, 32'h0, 1'b0, 4'h0, ga, gd);
        check("b2b_first", gd, 32'h0001_0000);
        step(1'b0, 1'b1, 20'h00018, 32'h0, 1'b0, 4'h0, ga, gd);
        check("b2b_second_ack", {31'b0, ga}, 32'h1);
        check("b2b_second", gd, 32'h55);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            wr = (r < 3) || (r == 9);
            rd = (r >= 3 && r < 7) || (r == 9);
            step(wr, rd, rand_addrs[$urandom_range(0, 11)], $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, ga, gd);
        end

        // reset with an ack pending
        step(1'b1, 1'b0, 20'h00004, 32'h1, 1'b0, 4'h0, ga, gd);
        step(1'b1, 1'b0, 20'h0000C, 32'h0000_1234, 1'b0, 4'h0, ga, gd);
        step(1'b1, 1'b0, 20'h00018, 32'hCAFE_F00D, 1'b1, 4'h0, ga, gd);
        req_rd   = 1'b1;
        req_addr = 20'h00000;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0;
        check("rst_mid_ack", {31'b0, resp_ack}, 32'h0);
        check("rst_mid_rdata", resp_data, 32'h0);
        check("rst_mid_enable", {31'b0, demod_enable}, 32'h0);
        check("rst_mid_clear", {31'b0, stats_clear}, 32'h0);
        check("rst_mid_num_sym", {16'b0, num_sym}, 32'd14);
        check("rst_mid_thresh", est_thresh, 32'h0);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 20'h00018, 32'h0, 1'b0, 4'h0, ga, gd);
        check("rst_mid_scratch", gd, 32'h0);
        step(1'b0, 1'b1, 20'h00010, 32'h0, 1'b0, 4'h0, ga, gd);
        check("rst_mid_pkt_cnt", gd, 32'h0);
        step(1'b0, 1'b1, 20'h00014, 32'h0, 1'b0, 4'h0, ga, gd);
        check("rst_mid_err", gd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/demodchest_ctrlport_regs.md
Name: demodchest_ctrlport_regs

Overview:
- CtrlPort responder (slave) for the demodchest block; answers requests from the NoC shell's CtrlPort master.
- Holds the block's configuration registers and drives them to the datapath.
- Collects datapath status as a saturating packet counter and clear-on-read sticky error flags.
- Sits between the shell's m_ctrlport_* bus and the demod/channel-estimation core, in the ctrlport clock domain.

Parameters:
- BASE_ADDR, 20'h0, start of this block's register window; must be aligned to 2**ADDR_W.
- ADDR_W, 8, byte-address width of the window.
- COMPAT, 32'h0001_0000, value returned by REG_COMPAT (major[31:16], minor[15:0]).
- NUM_ERR, 4, number of sticky error inputs (1..32).

Ports:
- ctrlport_clk, in, 1, sole clock.
- ctrlport_rst_n, in, 1, asynchronous active-low reset.
- s_ctrlport_req_wr, in, 1, write strobe (single cycle).
- s_ctrlport_req_rd, in, 1, read strobe (single cycle).
- s_ctrlport_req_addr, in, 20, byte address.
- s_ctrlport_req_data, in, 32, write data.
- s_ctrlport_resp_ack, out, 1, response strobe.
- s_ctrlport_resp_data, out, 32, read data; valid only with ack.
- demod_enable, out, 1, REG_CTRL[0].
- stats_clear, out, 1, one-cycle pulse when REG_CTRL[1] is written 1.
- num_sym, out, 16, REG_NUM_SYM[15:0].
- est_thresh, out, 32, REG_THRESH.
- pkt_done, in, 1, one-cycle pulse per completed packet.
- err_in, in, NUM_ERR, per-bit error event pulses.

Behaviour:
- Reset (async assert, sync release): ack=0, resp_data=0, demod_enable=0, stats_clear=0, num_sym=16'd14, est_thresh=0, scratch=0, pkt_cnt=0, err_sticky=0.
- Address hit: addr[19:ADDR_W]==BASE_ADDR[19:ADDR_W]. Offset = addr[ADDR_W-1:0]; only word-aligned offsets decode.
- Misses (outside the window): no ack and no state change, because other responders share the bus.
- Register map (offsets):
  - 0x00 COMPAT, RO.
  - 0x04 CTRL: bit0 RW; bit1 WO self-clearing, reads 0.
  - 0x08 NUM_SYM: RW [15:0], reads [31:16]=0.
  - 0x0C THRESH: RW.
  - 0x10 PKT_CNT: RO.
  - 0x14 ERR_STATUS: RO, clear-on-read, [NUM_ERR-1:0].
  - 0x18 SCRATCH: RW.
- Unmapped offsets inside the window: ack, read data 0, writes ignored.
- Latency: ack is asserted exactly 1 cycle after a hit strobe, for 1 cycle. resp_data is registered with ack and forced to 0 for writes and on idle cycles.
- Back-to-back strobes on consecutive cycles each get their own ack; there is no request buffering.
- wr and rd in the same cycle (protocol violation): treat as write, single ack, data 0.
- Written register values appear on outputs 1 cycle after the write strobe, coincident with ack.
- stats_clear pulses in the same cycle as ack.
- pkt_cnt:
  - Increments on pkt_done and saturates at 32'hFFFF_FFFF.
  - Cleared by stats_clear; a clear takes priority over a coincident pkt_done.
- err_sticky:
  - Per-bit, set by err_in.
  - A read of ERR_STATUS returns the current value and clears only the bits returned.
  - An err_in bit arriving in the read cycle stays set for the next read, so no event is lost.
  - stats_clear also clears err_sticky; err_in in that cycle still sets.
- Reset mid-transaction: a pending ack is dropped; the master's timeout handles it.

Decomposition:
- Package demodchest_regs_pkg holds:
  - Offset localparams REG_COMPAT..REG_SCRATCH.
  - CTRL bit indices CTRL_ENABLE_BIT=0 and CTRL_CLEAR_BIT=1.
  - NUM_SYM reset value 16'd14.
- One natural sub-module: sticky_clr_on_read, a NUM_ERR-wide set/clear-on-read register with set-priority. Everything else stays inline.

Test Plan:
1. Reset value checks:
   - Release reset, read 0x00 -> ack 1 cycle later, data 32'h0001_0000.
   - Read 0x08 -> 14.
   - Read 0x04 -> 0.
2. Write/read and miss checks:
   - Write SCRATCH=32'hDEAD_BEEF, then read -> DEAD_BEEF.
   - Write THRESH=32'h0000_1234 -> est_thresh=1234 in the ack cycle.
   - Access with BASE_ADDR+0x100 (ADDR_W=8) -> no ack ever.
3. Packet counter and clear:
   - 5 pkt_done pulses -> PKT_CNT=5.
   - Write CTRL=32'h3 -> stats_clear high for exactly 1 cycle, demod_enable=1, PKT_CNT=0, CTRL reads 1.
4. Clear-on-read race:
   - Pulse err_in=4'b0001, then read ERR_STATUS while err_in=4'b0100 in the read cycle -> returns 0001.
   - Next read -> 0100.
   - Third read -> 0.
5. Saturation: force pkt_cnt=32'hFFFF_FFFE, apply 3 pulses -> reads FFFF_FFFF.
6. Unmapped, back-to-back and reset cases:
   - Read 0x3C -> ack, data 0.
   - Read 0x00 and 0x18 on consecutive cycles -> two consecutive acks with correct data.
   - Assert ctrlport_rst_n low during the ack-pending cycle -> ack stays 0 and all outputs return to reset values.
